// File: rtl/truth_table_scanner_pkg.sv
// Shared constants and state encoding for the truth-table scanner.
package truth_table_scanner_pkg;

    localparam int unsigned NUM_MINTERMS = 16;
    localparam int unsigned W_WIDTH      = 4;
    localparam int unsigned ONES_WIDTH   = 5;
    localparam int unsigned CNT_WIDTH    = 4;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_RUN  = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_e;

    // True when the select bus sits on the final minterm of the sweep.
    function automatic logic is_last_minterm(input logic [W_WIDTH-1:0] w);
        return w == W_WIDTH'(NUM_MINTERMS - 1);
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Hold-time counter: counts 0..SETTLE-1 while enabled and flags the last hold cycle.
module settle_timer
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    assign tick = (count_q == CNT_WIDTH'(SETTLE - 1));

    // Next count: clear wins, otherwise advance and wrap on tick.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + CNT_WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps W through all 16 minterms, captures F per minterm, counts ones and
// compares the captured table against a reference latched at start.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    start,
    input  logic                    F,
    input  logic [NUM_MINTERMS-1:0] expected,
    output logic [W_WIDTH-1:0]      W,
    output logic [NUM_MINTERMS-1:0] table_out,
    output logic [ONES_WIDTH-1:0]   ones,
    output logic                    busy,
    output logic                    done,
    output logic                    match
);

    scan_state_e state_q, state_d;

    logic [W_WIDTH-1:0]      w_q;
    logic [NUM_MINTERMS-1:0] table_q, table_next;
    logic [NUM_MINTERMS-1:0] expected_q;
    logic [ONES_WIDTH-1:0]   ones_q;
    logic                    match_q;
    logic                    start_accept;
    logic                    tick;
    logic                    sample;

    // Start is only honoured outside an active sweep.
    assign start_accept = start && (state_q != SCAN_RUN);
    assign sample       = (state_q == SCAN_RUN) && tick;

    settle_timer #(
        .SETTLE(SETTLE)
    ) u_settle_timer (
        .Clock (Clock),
        .Resetn(Resetn),
        .clear (start_accept),
        .enable(state_q == SCAN_RUN),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= SCAN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN_IDLE: if (start) state_d = SCAN_RUN;
            SCAN_RUN:  if (sample && is_last_minterm(w_q)) state_d = SCAN_DONE;
            SCAN_DONE: if (start) state_d = SCAN_RUN;
            default:   state_d = SCAN_IDLE;
        endcase
    end

    // Table with the current sample merged in, so the final compare sees the last bit.
    always_comb begin
        table_next      = table_q;
        table_next[w_q] = F;
    end

    // Capture, popcount and compare datapath.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            w_q        <= '0;
            table_q    <= '0;
            ones_q     <= '0;
            match_q    <= 1'b0;
            expected_q <= '0;
        end else if (start_accept) begin
            w_q        <= '0;
            table_q    <= '0;
            ones_q     <= '0;
            match_q    <= 1'b0;
            expected_q <= expected;
        end else if (sample) begin
            table_q <= table_next;
            ones_q  <= ones_q + ONES_WIDTH'(F);
            if (is_last_minterm(w_q)) begin
                match_q <= (table_next == expected_q);
            end else begin
                w_q <= w_q + W_WIDTH'(1);
            end
        end
    end

    // Outputs; busy and done decode from the state so they are exclusive.
    always_comb begin
        W         = w_q;
        table_out = table_q;
        ones      = ones_q;
        busy      = (state_q == SCAN_RUN);
        done      = (state_q == SCAN_DONE);
        match     = match_q;
    end

endmodule
